stream_mux_rr: RTL and testbench
================================

# stream_mux_rr

Parametrised N-channel, W-bit streaming multiplexer with an arbitrated select and a registered output stage. It generalises the team's combinational 4:1 one-bit mux: channel count and data width are parameters, each channel has a valid/ready handshake, and select is generated internally by fixed-priority or round-robin arbitration with optional packet locking. It sits between several producer streams and a single shared consumer, such as a bus or serializer.

## Interface
Parameters:
- WIDTH, 8, data bits per channel (≥1)
- NCH, 4, number of input channels (≥1)
- MODE, 1, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin
- LOCK, 1, 1 = hold grant until a beat with last is accepted; 0 = re-arbitrate every beat

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  NCH  per-channel valid
- in_data  in  NCH*WIDTH  channel i at bits [i*WIDTH +: WIDTH]
- in_last  in  NCH  per-channel end-of-packet flag
- in_ready  out  NCH  per-channel accept
- out_valid  out  1  output register holds a beat
- out_data  out  WIDTH  registered data
- out_last  out  1  registered last
- out_sel  out  SELW  source channel of the current output beat; SELW = (NCH>1) ? $clog2(NCH) : 1
- out_ready  in  1  consumer accept

## Operation
- Input transfer on channel i: in_valid[i] & in_ready[i]. Output transfer: out_valid & out_ready.
- can_load = ~out_valid | out_ready.
- Grant is one-hot or zero, derived combinationally from in_valid, the pointer, and the lock state.
- in_ready[i] = grant[i] & can_load. At most one bit is ever high.
- FSM (used only when LOCK=1):
  - IDLE → LOCKED on an accepted beat with in_last=0; lock_ch is set to the granted channel.
  - LOCKED → IDLE on an accepted beat from lock_ch with in_last=1.
  - In LOCKED, grant = lock_ch only, even if in_valid[lock_ch]=0. This produces a bubble, and no other channel is granted.
- When LOCK=0 the FSM stays in IDLE permanently.
- Arbitration in IDLE:
  - MODE=0: lowest-index valid channel.
  - MODE=1: first valid channel at or after ptr, searching upward modulo NCH.
- Pointer (MODE=1): after an accepted beat that ends arbitration, ptr ← granted+1, wrapping NCH-1 → 0.
  - A beat ends arbitration when it has last=1 or when LOCK=0.
  - In MODE=0 the pointer is unused and held at 0.
- On an input transfer: out_data ← selected in_data, out_last ← in_last, out_sel ← index, out_valid ← 1.
- On an output transfer with no input transfer in the same cycle, out_valid ← 0.
- While out_valid=1 and out_ready=0, out_data, out_last and out_sel are held stable.
- Simultaneous output and input transfer: the register reloads in the same cycle, with no bubble.
- NCH=1: the arbiter degenerates to grant = in_valid[0], and out_sel is always 0.

## Timing
- Reset (rst_n=0, asynchronous): out_valid=0, out_data=0, out_last=0, out_sel=0, ptr=0, FSM=IDLE, lock_ch=0. in_ready is forced to 0 while reset is asserted.
- Reset mid-packet drops the lock and the pending output beat. There is no recovery of the dropped beat.
- Latency: an accepted input beat appears on out_* on the next cycle.
- Throughput: 1 beat/cycle sustained while out_ready=1.
- in_ready depends combinationally on out_valid, out_ready and in_valid. There is no combinational path from in_data to any output.
- Arbitration decisions take effect on the cycle after the transfer that updates ptr or the lock state.

## Structure
- Package stream_mux_pkg holds:
  - MODE_FIXED=0 and MODE_RR=1 constants
  - the FSM state enum {ST_IDLE, ST_LOCKED}
  - a function computing SELW from NCH
- Sub-module rr_arbiter (params NCH, MODE):
  - inputs: req[NCH], ptr
  - outputs: one-hot grant and encoded index
  - purely combinational, implemented with a double-width rotate-and-priority scheme
- The top level holds the FSM, the pointer, and the output register.

## Test plan
- Reset: assert rst_n=0 mid-stream with out_valid=1 → out_valid=0, out_sel=0, in_ready=0 immediately; after release, first grant goes to channel 0.
- Round-robin (MODE=1, LOCK=0, NCH=4): all valid, out_ready=1 → out_sel sequence 0,1,2,3,0 on consecutive cycles with ptr wrap; data matches the per-channel pattern 8'hA0+i.
- Fixed priority (MODE=0): ch1 and ch3 valid continuously → only ch1 is granted; ch3 is granted only after ch1 drops valid.
- Packet lock (LOCK=1): ch2 sends a 3-beat packet (last on beat 3) while ch0 is valid → out_sel=2 for 3 beats. A ch2 valid gap of 2 cycles mid-packet causes bubbles with no ch0 grant. ch0 is granted on the cycle after ch2's last beat is accepted.
- Backpressure: out_ready=0 for 5 cycles with out_valid=1 → out_data, out_last and out_sel are stable and all in_ready=0. When out_ready returns to 1, a reload happens in the same cycle with no lost or duplicated beats (scoreboard count equal).
- NCH=1, WIDTH=16: stream 16'h1234, 16'hBEEF → out_sel=0, one-cycle latency, in_ready mirrors can_load.

Source files
------------

// File: rtl/stream_mux_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | stream_mux_pkg : shared constants and types for stream_mux_rr      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package stream_mux_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    function automatic int calc_selw(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage : stream_mux_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_arbiter : combinational fixed-priority / round-robin arbiter    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int MODE = MODE_RR,
    parameter int SELW = calc_selw(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic [NCH-1:0]  grant,
    output logic [SELW-1:0] idx
);

    logic [2*NCH-1:0] w_dbl;
    logic [NCH-1:0]   w_rot;
    logic [SELW-1:0]  w_ptr;
    logic [SELW-1:0]  w_off;
    logic [SELW:0]    w_sum;
    logic             w_found;

    // Rotate requests so the search always starts at bit 0, then map the
    // winning offset back to an absolute channel index.
    always_comb begin
        w_ptr   = (MODE == MODE_RR && NCH > 1) ? ptr : '0;
        w_dbl   = {req, req} >> w_ptr;
        w_rot   = w_dbl[NCH-1:0];
        w_found = 1'b0;
        w_off   = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_found = 1'b1;
                w_off   = SELW'(k);
            end
        end
        w_sum = {1'b0, w_ptr} + {1'b0, w_off};
        if (w_sum >= (SELW+1)'(NCH)) begin
            w_sum = w_sum - (SELW+1)'(NCH);
        end
        idx   = w_sum[SELW-1:0];
        grant = '0;
        if (w_found) begin
            grant[idx] = 1'b1;
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/stream_mux_rr.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | stream_mux_rr : N-channel arbitrated stream mux, registered output |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int MODE  = MODE_RR,
    parameter int LOCK  = 1,
    localparam int SELW = calc_selw(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_last,
    output logic [NCH-1:0]       in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_last,
    output logic [SELW-1:0]      out_sel,
    input  logic                 out_ready
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SELW-1:0]  r_lock_ch;
    logic [SELW-1:0]  r_ptr;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_last;
    logic [SELW-1:0]  r_out_sel;

    logic [NCH-1:0]   w_arb_grant;
    logic [SELW-1:0]  w_arb_idx;
    logic [NCH-1:0]   w_grant;
    logic [SELW-1:0]  w_idx;
    logic [SELW:0]    w_idx_inc;
    logic [SELW-1:0]  w_idx_next;
    logic             w_can_load;
    logic             w_xfer;
    logic             w_sel_last;
    logic [WIDTH-1:0] w_sel_data;

    rr_arbiter #(
        .NCH  (NCH),
        .MODE (MODE),
        .SELW (SELW)
    ) u_arb (
        .req   (in_valid),
        .ptr   (r_ptr),
        .grant (w_arb_grant),
        .idx   (w_arb_idx)
    );

    // While locked, the owning channel keeps the grant even with valid low,
    // so a gap in its packet shows up as a bubble rather than a hand-over.
    always_comb begin
        w_grant = w_arb_grant;
        w_idx   = w_arb_idx;
        if (LOCK != 0 && r_state == ST_LOCKED) begin
            w_grant            = '0;
            w_grant[r_lock_ch] = 1'b1;
            w_idx              = r_lock_ch;
        end
    end

    assign w_can_load = ~r_out_valid | out_ready;
    assign in_ready   = rst_n ? (w_grant & {NCH{w_can_load}}) : '0;
    assign w_xfer     = |(in_valid & in_ready);
    assign w_sel_last = in_last[w_idx];
    assign w_sel_data = in_data[int'(w_idx)*WIDTH +: WIDTH];

    always_comb begin
        w_idx_inc  = {1'b0, w_idx} + 1'b1;
        w_idx_next = w_idx_inc[SELW-1:0];
        if (w_idx_inc >= (SELW+1)'(NCH)) begin
            w_idx_next = '0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (LOCK != 0) begin
            case (r_state)
                ST_IDLE:   if (w_xfer && !w_sel_last) w_state_nxt = ST_LOCKED;
                ST_LOCKED: if (w_xfer &&  w_sel_last) w_state_nxt = ST_IDLE;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_lock_ch <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && w_state_nxt == ST_LOCKED) begin
                r_lock_ch <= w_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (MODE == MODE_RR && w_xfer && (w_sel_last || LOCK == 0)) begin
            r_ptr <= w_idx_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_sel   <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sel_data;
            r_out_last  <= w_sel_last;
            r_out_sel   <= w_idx;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_sel   = r_out_sel;

endmodule : stream_mux_rr
`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
`default_nettype none
// Directed, table-driven bench for stream_mux_rr over four configurations.
module tb_stream_mux_rr;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // RR, no lock
    logic [3:0] rr_v, rr_l, rr_ir;  logic [31:0] rr_d;
    logic rr_ov, rr_ol, rr_or;      logic [1:0] rr_sel; logic [7:0] rr_od;
    // fixed priority, no lock
    logic [3:0] fp_v, fp_l, fp_ir;  logic [31:0] fp_d;
    logic fp_ov, fp_ol, fp_or;      logic [1:0] fp_sel; logic [7:0] fp_od;
    // RR with packet lock
    logic [3:0] lk_v, lk_l, lk_ir;  logic [31:0] lk_d;
    logic lk_ov, lk_ol, lk_or;      logic [1:0] lk_sel; logic [7:0] lk_od;
    // single channel, 16-bit
    logic [0:0] n1_v, n1_l, n1_ir;  logic [15:0] n1_d;
    logic n1_ov, n1_ol, n1_or;      logic [0:0] n1_sel; logic [15:0] n1_od;

    stream_mux_rr #(.WIDTH(8), .NCH(4), .MODE(1), .LOCK(0)) u_rr (
        .clk(clk), .rst_n(rst_n), .in_valid(rr_v), .in_data(rr_d), .in_last(rr_l),
        .in_ready(rr_ir), .out_valid(rr_ov), .out_data(rr_od), .out_last(rr_ol),
        .out_sel(rr_sel), .out_ready(rr_or));
    stream_mux_rr #(.WIDTH(8), .NCH(4), .MODE(0), .LOCK(0)) u_fp (
        .clk(clk), .rst_n(rst_n), .in_valid(fp_v), .in_data(fp_d), .in_last(fp_l),
        .in_ready(fp_ir), .out_valid(fp_ov), .out_data(fp_od), .out_last(fp_ol),
        .out_sel(fp_sel), .out_ready(fp_or));
    stream_mux_rr #(.WIDTH(8), .NCH(4), .MODE(1), .LOCK(1)) u_lk (
        .clk(clk), .rst_n(rst_n), .in_valid(lk_v), .in_data(lk_d), .in_last(lk_l),
        .in_ready(lk_ir), .out_valid(lk_ov), .out_data(lk_od), .out_last(lk_ol),
        .out_sel(lk_sel), .out_ready(lk_or));
    stream_mux_rr #(.WIDTH(16), .NCH(1), .MODE(1), .LOCK(1)) u_n1 (
        .clk(clk), .rst_n(rst_n), .in_valid(n1_v), .in_data(n1_d), .in_last(n1_l),
        .in_ready(n1_ir), .out_valid(n1_ov), .out_data(n1_od), .out_last(n1_ol),
        .out_sel(n1_sel), .out_ready(n1_or));

    int lk_outcnt = 0;
    always @(posedge clk) if (lk_ov && lk_or) lk_outcnt++;

    typedef struct {
        logic [3:0] vld;
        logic       rdy;
        logic [3:0] exp_ir;
        logic       exp_ov;
        logic [1:0] exp_sel;
        logic [7:0] exp_dat;
    } rr_vec_t;

    typedef struct {
        logic [3:0] vld;
        logic       l2;
        logic [7:0] d2;
        logic [3:0] exp_ir;
        logic       exp_ov;
        logic [1:0] exp_sel;
        logic [7:0] exp_dat;
        logic       exp_last;
    } lk_vec_t;

    rr_vec_t rr_tbl[12];
    lk_vec_t lk_tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rr_tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};
        rr_tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1};
        rr_tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2};
        rr_tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3};
        rr_tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};
        rr_tbl[5]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 8'hA0};
        rr_tbl[6]  = '{4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3};
        rr_tbl[7]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 8'hA3};
        rr_tbl[8]  = '{4'b0110, 1'b0, 4'b0010, 1'b1, 2'd1, 8'hA1};
        rr_tbl[9]  = '{4'b0110, 1'b0, 4'b0000, 1'b1, 2'd1, 8'hA1};
        rr_tbl[10] = '{4'b0110, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2};
        rr_tbl[11] = '{4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};

        lk_tbl[0] = '{4'b0100, 1'b0, 8'h21, 4'b0100, 1'b1, 2'd2, 8'h21, 1'b0};
        lk_tbl[1] = '{4'b0001, 1'b0, 8'h21, 4'b0100, 1'b0, 2'd2, 8'h21, 1'b0};
        lk_tbl[2] = '{4'b0001, 1'b0, 8'h21, 4'b0100, 1'b0, 2'd2, 8'h21, 1'b0};
        lk_tbl[3] = '{4'b0101, 1'b0, 8'h22, 4'b0100, 1'b1, 2'd2, 8'h22, 1'b0};
        lk_tbl[4] = '{4'b0101, 1'b1, 8'h23, 4'b0100, 1'b1, 2'd2, 8'h23, 1'b1};
        lk_tbl[5] = '{4'b0001, 1'b0, 8'h23, 4'b0001, 1'b1, 2'd0, 8'h05, 1'b1};

        rr_v = '0; rr_l = 4'hF; rr_d = 32'hA3A2A1A0; rr_or = 1'b0;
        fp_v = '0; fp_l = 4'hF; fp_d = 32'hA3A2A1A0; fp_or = 1'b0;
        lk_v = '0; lk_l = 4'b0001; lk_d = 32'h00000005; lk_or = 1'b1;
        n1_v = '0; n1_l = 1'b1; n1_d = '0; n1_or = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_rr_ov",  32'(rr_ov),  32'd0);
        chk("reset_rr_od",  32'(rr_od),  32'd0);
        chk("reset_rr_sel", 32'(rr_sel), 32'd0);
        chk("reset_lk_ol",  32'(lk_ol),  32'd0);
        chk("reset_n1_od",  32'(n1_od),  32'd0);
        rst_n = 1'b1;

        // Round-robin rotation, wrap and backpressure
        for (int i = 0; i < 12; i++) begin
            rr_v  = rr_tbl[i].vld;
            rr_or = rr_tbl[i].rdy;
            #1;
            chk($sformatf("rr%0d_ir", i), 32'(rr_ir), 32'(rr_tbl[i].exp_ir));
            tick();
            chk($sformatf("rr%0d_ov", i),  32'(rr_ov),  32'(rr_tbl[i].exp_ov));
            chk($sformatf("rr%0d_sel", i), 32'(rr_sel), 32'(rr_tbl[i].exp_sel));
            chk($sformatf("rr%0d_dat", i), 32'(rr_od),  32'(rr_tbl[i].exp_dat));
        end
        rr_v = '0; rr_or = 1'b1;

        // Fixed priority: ch1 starves ch3 until it drops
        fp_or = 1'b1;
        for (int i = 0; i < 5; i++) begin
            fp_v = (i == 3) ? 4'b1000 : 4'b1010;
            #1;
            chk($sformatf("fp%0d_ir", i), 32'(fp_ir), (i == 3) ? 32'h8 : 32'h2);
            tick();
            chk($sformatf("fp%0d_sel", i), 32'(fp_sel), (i == 3) ? 32'd3 : 32'd1);
            chk($sformatf("fp%0d_dat", i), 32'(fp_od),  (i == 3) ? 32'hA3 : 32'hA1);
        end
        fp_v = '0;

        // Packet lock on ch2 with a two-cycle gap
        for (int i = 0; i < 6; i++) begin
            lk_v         = lk_tbl[i].vld;
            lk_l[2]      = lk_tbl[i].l2;
            lk_d[23:16]  = lk_tbl[i].d2;
            #1;
            chk($sformatf("lk%0d_ir", i), 32'(lk_ir), 32'(lk_tbl[i].exp_ir));
            tick();
            chk($sformatf("lk%0d_ov", i),   32'(lk_ov),  32'(lk_tbl[i].exp_ov));
            chk($sformatf("lk%0d_sel", i),  32'(lk_sel), 32'(lk_tbl[i].exp_sel));
            chk($sformatf("lk%0d_dat", i),  32'(lk_od),  32'(lk_tbl[i].exp_dat));
            chk($sformatf("lk%0d_last", i), 32'(lk_ol),  32'(lk_tbl[i].exp_last));
        end

        // Backpressure: output frozen for 5 cycles, then same-cycle reload
        lk_outcnt   = 0;
        lk_v        = 4'b0001;
        lk_d[7:0]   = 8'h30;
        lk_or       = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("bp%0d_ir", i), 32'(lk_ir), 32'd0);
            tick();
            chk($sformatf("bp%0d_hold", i),
                {22'd0, lk_ov, lk_ol, lk_sel, lk_od}, {22'd0, 1'b1, 1'b1, 2'd0, 8'h05});
        end
        lk_or = 1'b1;
        #1;
        chk("bp_reload_ir", 32'(lk_ir), 32'h1);
        tick();
        chk("bp_reload_dat", 32'(lk_od), 32'h30);
        lk_d[7:0] = 8'h31;
        tick();
        chk("bp_next_dat", 32'(lk_od), 32'h31);
        lk_v = '0;
        tick();
        chk("bp_drain_ov", 32'(lk_ov), 32'd0);
        chk("bp_beat_count", 32'(lk_outcnt), 32'd3);

        // Single channel
        n1_v = 1'b1; n1_d = 16'h1234; n1_or = 1'b1;
        #1;
        chk("n1_a_ir", 32'(n1_ir), 32'd1);
        tick();
        chk("n1_a_dat", {15'd0, n1_ov, n1_od}, {15'd0, 1'b1, 16'h1234});
        chk("n1_a_sel", 32'(n1_sel), 32'd0);
        n1_d = 16'hBEEF; n1_or = 1'b0;
        #1;
        chk("n1_b_ir", 32'(n1_ir), 32'd0);
        tick();
        chk("n1_b_hold", 32'(n1_od), 32'h1234);
        n1_or = 1'b1;
        #1;
        chk("n1_c_ir", 32'(n1_ir), 32'd1);
        tick();
        chk("n1_c_dat", 32'(n1_od), 32'hBEEF);
        n1_v = 1'b0;
        tick();
        chk("n1_d_ov", 32'(n1_ov), 32'd0);

        // Asynchronous reset mid-stream (rr ptr is nonzero here)
        rr_v = 4'b1111; rr_or = 1'b1;
        tick();
        rr_or = 1'b0;
        chk("pre_rst_ov", 32'(rr_ov), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_ov",  32'(rr_ov),  32'd0);
        chk("rst_sel", 32'(rr_sel), 32'd0);
        chk("rst_ir",  32'(rr_ir),  32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rr_or = 1'b1;
        #1;
        chk("post_rst_ir", 32'(rr_ir), 32'h1);
        tick();
        chk("post_rst_sel", 32'(rr_sel), 32'd0);
        chk("post_rst_dat", 32'(rr_od),  32'hA0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_stream_mux_rr
`default_nettype wire
